// File: rtl/buzzer_seq_pkg.sv
// rtl/buzzer_seq_pkg.sv - shared types and default constants for the buzzer sequencer
package buzzer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_GAP
    } seq_state_e;

    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_COUNT_W        = 3;
    localparam int DEFAULT_GAP_CYCLES     = 2500;
    localparam int DEFAULT_TIMEOUT_CYCLES = 10000;

    typedef logic [DEFAULT_COUNT_W-1:0] beep_count_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/buzzer_req_fifo.sv
// rtl/buzzer_req_fifo.sv - synchronous request FIFO with flush
// DEPTH must be a power of two; pointers wrap naturally.
module buzzer_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// rtl/buzzer_sequencer.sv - turns queued "N beeps" requests into spaced buzzer start pulses
// BUZZER_SEQ_ABORT_EN adds an abort input that flushes the queue and returns to IDLE.
module buzzer_sequencer
    import buzzer_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int COUNT_W        = DEFAULT_COUNT_W,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COUNT_W-1:0] req_count,
    output logic               start_buzzer,
    input  logic               buzzer_out,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
`ifdef BUZZER_SEQ_ABORT_EN
    ,
    input  logic               abort
`endif
);
    localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES)) + 1;
    // Timer holds WAIT cycles already elapsed, so expiry lands TIMEOUT_CYCLES after FIRE.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    seq_state_e         state_q, state_d;
    logic [COUNT_W-1:0] rem_q, rem_d, fifo_data;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               err_q, set_err;
    logic               fifo_full, fifo_empty, push, pop, abort_w;

`ifdef BUZZER_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign req_ready   = !fifo_full && !abort_w;
    assign push        = req_valid && req_ready;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign timeout_err = err_q;

    buzzer_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (COUNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_w),
        .push      (push),
        .push_data (req_count),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            if (push)         err_q <= 1'b0;
            else if (set_err) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        start_buzzer = 1'b0;
        done         = 1'b0;
        set_err      = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    rem_d   = fifo_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = (rem_q == '0) ? ST_IDLE : ST_FIRE;
            ST_FIRE: begin
                start_buzzer = 1'b1;
                cnt_d        = '0;
                state_d      = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!buzzer_out) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_HIGH;
                end else if (cnt_q >= TMO_LAST) begin
                    set_err = 1'b1;
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_HIGH: begin
                if (buzzer_out) begin
                    rem_d = rem_q - COUNT_W'(1);
                    if (rem_q == COUNT_W'(1)) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end else if (cnt_q >= TMO_LAST) begin
                    set_err = 1'b1;
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) state_d = ST_FIRE;
                else                   cnt_d   = cnt_inc;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w) begin
            state_d      = ST_IDLE;
            rem_d        = '0;
            cnt_d        = '0;
            start_buzzer = 1'b0;
            done         = 1'b0;
            pop          = 1'b0;
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb/tb_buzzer_sequencer.sv - self-checking bench with a reactive buzzer model and timing reference
module tb_buzzer_sequencer;
    localparam int GAP   = 25;
    localparam int TMO   = 200;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [CW-1:0] req_count = '0;
    logic          buzzer_out = 1'b1;
    logic          req_ready, start_buzzer, busy, done, timeout_err;
`ifdef BUZZER_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    buzzer_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .COUNT_W        (CW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_count    (req_count),
        .start_buzzer (start_buzzer),
        .buzzer_out   (buzzer_out),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
`ifdef BUZZER_SEQ_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int starts[$], dones[$];
    int exp_starts[$], exp_dones[$];
    int bd[64], bl[64];
    int bz_idx = 0, bi;
    bit bz_stuck = 1'b0, bz_active = 1'b0;
    int idle_at = 0, beep_ptr = 0;

    initial forever begin
        @(negedge clk);
        if (start_buzzer === 1'b1) starts.push_back(cyc);
        if (done === 1'b1) dones.push_back(cyc);
    end

    // Buzzer: after a start, stays high bd cycles, sounds (low) for bl cycles, then releases.
    initial forever begin
        @(negedge clk);
        if (start_buzzer === 1'b1 && !bz_stuck) begin
            bi = bz_idx;
            bz_idx++;
            bz_active = 1'b1;
            repeat (bd[bi] + 1) @(posedge clk);
            #1 buzzer_out = 1'b0;
            repeat (bl[bi]) @(posedge clk);
            #1 buzzer_out = 1'b1;
            bz_active = 1'b0;
        end
    end

    // Reference: a request accepted in cycle a is popped when the FSM is next idle,
    // fires two cycles later, and each beep ends on the first cycle the buzzer is high again.
    task automatic model_req(input int a, input int cnt);
        int p, f, h;
        p = (a + 1 > idle_at) ? a + 1 : idle_at;
        if (cnt == 0) begin
            idle_at = p + 2;
        end else begin
            f = p + 2;
            for (int k = 0; k < cnt; k++) begin
                exp_starts.push_back(f);
                h = f + 1 + bd[beep_ptr] + bl[beep_ptr];
                beep_ptr++;
                if (k == cnt - 1) begin
                    exp_dones.push_back(h);
                    idle_at = h + 1;
                end else begin
                    f = h + GAP + 1;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int cnt, output int acc, output logic rdy);
        req_valid = 1'b1;
        req_count = CW'(cnt);
        @(negedge clk);
        rdy = req_ready;
        acc = cyc;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic begin_test();
        starts.delete(); dones.delete(); exp_starts.delete(); exp_dones.delete();
        bz_idx = 0;
        beep_ptr = 0;
        for (int i = 0; i < 64; i++) begin
            bd[i] = $urandom_range(0, 12);
            bl[i] = $urandom_range(1, 60);
        end
    endtask

    task automatic wait_idle();
        while (cyc < idle_at + 2 || bz_active) tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (start_buzzer !== 1'b0) begin n_fail++; $display("FAIL reset start_buzzer: got %b expected 0", start_buzzer); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset timeout_err: got %b expected 0", timeout_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        idle_at = cyc;
        tick(1);
    endtask

    task automatic test_requests(input string name, input int nreq);
        int acc;
        logic rdy;
        int cnts[$];
        begin_test();
        for (int r = 0; r < nreq; r++) cnts.push_back((nreq == 1) ? 2 : $urandom_range(0, 3));
        foreach (cnts[r]) begin
            push_req(cnts[r], acc, rdy);
            n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b expected 1", name, rdy); end
            model_req(acc, cnts[r]);
        end
        wait_idle();
        n_cmp++; if (starts.size() != exp_starts.size()) begin n_fail++; $display("FAIL %s start count: got %0d expected %0d", name, starts.size(), exp_starts.size()); end
        for (int i = 0; i < starts.size() && i < exp_starts.size(); i++) begin
            n_cmp++; if (starts[i] != exp_starts[i]) begin n_fail++; $display("FAIL %s start[%0d] cycle: got %0d expected %0d", name, i, starts[i], exp_starts[i]); end
        end
        n_cmp++; if (dones.size() != exp_dones.size()) begin n_fail++; $display("FAIL %s done count: got %0d expected %0d", name, dones.size(), exp_dones.size()); end
        for (int i = 0; i < dones.size() && i < exp_dones.size(); i++) begin
            n_cmp++; if (dones[i] != exp_dones[i]) begin n_fail++; $display("FAIL %s done[%0d] cycle: got %0d expected %0d", name, i, dones[i], exp_dones[i]); end
        end
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL %s timeout_err: got %b expected 0", name, timeout_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy at end: got %b expected 0", name, busy); end
        tick(1);
    endtask

    task automatic test_zero_count();
        int acc;
        logic rdy;
        begin_test();
        push_req(0, acc, rdy);
        model_req(acc, 0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero busy while queued: got %b expected 1", busy); end
        tick(2);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero busy at accept+3: got %b expected 0", busy); end
        tick(10);
        n_cmp++; if (starts.size() != 0 || dones.size() != 0) begin n_fail++; $display("FAIL zero pulses: got %0d starts %0d dones expected 0 0", starts.size(), dones.size()); end
    endtask

    task automatic test_fifo_full();
        int acc, exp_acc;
        logic rdy;
        begin_test();
        bd[0] = 40;
        push_req(1, acc, rdy);
        model_req(acc, 1);
        tick(3);
        for (int r = 0; r < 4; r++) begin
            push_req(1, acc, rdy);
            n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL full push%0d req_ready: got %b expected 1", r, rdy); end
            model_req(acc, 1);
        end
        exp_acc = exp_dones[0] + 2;
        acc = -1;
        req_valid = 1'b1;
        req_count = CW'(1);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full 5th req_ready: got %b expected 0", req_ready); end
            end
            if (req_ready === 1'b1) begin acc = cyc; break; end
            tick(1);
        end
        tick(1);
        req_valid = 1'b0;
        n_cmp++; if (acc != exp_acc) begin n_fail++; $display("FAIL full 5th accept cycle: got %0d expected %0d", acc, exp_acc); end
        model_req(exp_acc, 1);
        wait_idle();
        n_cmp++; if (dones.size() != 6) begin n_fail++; $display("FAIL full done count: got %0d expected 6", dones.size()); end
        for (int i = 0; i < dones.size() && i < exp_dones.size(); i++) begin
            n_cmp++; if (dones[i] != exp_dones[i]) begin n_fail++; $display("FAIL full done[%0d] cycle: got %0d expected %0d", i, dones[i], exp_dones[i]); end
        end
        for (int i = 0; i < starts.size() && i < exp_starts.size(); i++) begin
            n_cmp++; if (starts[i] != exp_starts[i]) begin n_fail++; $display("FAIL full start[%0d] cycle: got %0d expected %0d", i, starts[i], exp_starts[i]); end
        end
    endtask

    task automatic test_timeout();
        int acc, f, first;
        logic rdy, busy_seen;
        begin_test();
        bz_stuck = 1'b1;
        push_req(2, acc, rdy);
        f = ((acc + 1 > idle_at) ? acc + 1 : idle_at) + 2;
        first = -1;
        busy_seen = 1'bx;
        while (cyc <= f + TMO + 2) begin
            @(negedge clk);
            if (timeout_err === 1'b1 && first < 0) first = cyc;
            if (cyc == f + TMO) busy_seen = busy;
            tick(1);
        end
        n_cmp++; if (first != f + TMO) begin n_fail++; $display("FAIL timeout rise cycle: got %0d expected %0d", first, f + TMO); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL timeout busy after expiry: got %b expected 0", busy_seen); end
        n_cmp++; if (starts.size() != 1 || dones.size() != 0) begin n_fail++; $display("FAIL timeout pulses: got %0d starts %0d dones expected 1 0", starts.size(), dones.size()); end
        idle_at = f + TMO;
        bz_stuck = 1'b0;
        begin_test();
        bd[0] = TMO - 2;
        bl[0] = 5;
        push_req(1, acc, rdy);
        model_req(acc, 1);
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout clear on accept: got %b expected 0", timeout_err); end
        wait_idle();
        n_cmp++; if (dones.size() != 1 || (dones.size() == 1 && dones[0] != exp_dones[0])) begin n_fail++; $display("FAIL timeout late-edge done: got %0d dones expected one at %0d", dones.size(), exp_dones[0]); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout late-edge err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int acc;
        logic rdy;
        begin_test();
        bd[0] = 0;
        bl[0] = 40;
        push_req(2, acc, rdy);
        push_req(1, acc, rdy);
        push_req(1, acc, rdy);
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid req_ready: got %b expected 1", req_ready); end
        tick(60);
        while (bz_active) tick(1);
        n_cmp++; if (starts.size() != 1 || dones.size() != 0) begin n_fail++; $display("FAIL reset_mid pulses: got %0d starts %0d dones expected 1 0", starts.size(), dones.size()); end
        idle_at = cyc;
    endtask

`ifdef BUZZER_SEQ_ABORT_EN
    task automatic test_abort();
        int acc, f, ab;
        logic rdy;
        begin_test();
        push_req(3, acc, rdy);
        f = ((acc + 1 > idle_at) ? acc + 1 : idle_at) + 2;
        push_req(1, acc, rdy);
        ab = f + 1 + bd[0] + bl[0] + 5;
        while (cyc < ab) tick(1);
        abort = 1'b1;
        req_valid = 1'b1;
        req_count = CW'(1);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort req_ready: got %b expected 0", req_ready); end
        tick(1);
        abort = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        tick(100);
        while (bz_active) tick(1);
        n_cmp++; if (starts.size() != 1 || dones.size() != 0) begin n_fail++; $display("FAIL abort pulses: got %0d starts %0d dones expected 1 0", starts.size(), dones.size()); end
        idle_at = cyc;
    endtask
`endif

    initial begin
        test_reset();
        test_requests("two_beeps", 1);
        for (int r = 0; r < 4; r++) test_requests("random", $urandom_range(2, 3));
        test_zero_count();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
`ifdef BUZZER_SEQ_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
